// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide issue controller: opcodes, unit latencies, FSM states.
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } md_op_e;

  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } md_state_e;

  // Opcodes 000..011 occupy the unit; bit 1 separates divide from multiply.
  function automatic logic is_arith(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic [3:0] lat_of(input logic [2:0] op);
    return op[1] ? DIV_LAT : MUL_LAT;
  endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Latency down-counter: load on issue, decrement while waiting, flag the final cycle (cnt==1).
module md_lat_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       term
);

  logic [3:0] cnt;

  assign term = (cnt == 4'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide issue controller: accepts E-stage mult/div ops, blocks for the unit latency.
// Optional MD_FLUSH_EN: flush cancels an in-flight wait and blocks issue while asserted.
module md_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  input  logic [2:0] op,
  output logic       op_ready,
  output logic       stall,
  input  logic       md_busy,
  output logic       md_start,
  output logic       md_hiwrite,
  output logic       md_lowrite,
  output logic [2:0] md_ctr,
  output logic       rd_valid,
  output logic       rd_sel,
  input  logic       flush
);

  import md_pkg::*;

  md_state_e  state;
  logic       flush_act;
  logic       fire;
  logic       arith;
  logic       term;
  logic [3:0] load_val;

`ifdef MD_FLUSH_EN
  assign flush_act = flush;
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign flush_act    = 1'b0;
`endif

  // All outputs are combinational; reset gates ready/stall low so nothing fires during reset.
  always_comb begin
    op_ready   = rst && (state == IDLE) && !md_busy && !flush_act;
    fire       = op_valid && op_ready;
    stall      = rst && op_valid && !op_ready;
    arith      = fire && is_arith(op);
    md_start   = arith;
    md_ctr     = arith ? {1'b0, op[1:0]} : '0;
    md_hiwrite = fire && (op == OP_MTHI);
    md_lowrite = fire && (op == OP_MTLO);
    rd_valid   = fire && (op[2:1] == 2'b11);
    rd_sel     = rd_valid && !op[0];
    load_val   = lat_of(op);
  end

  md_lat_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush_act),
    .load     (arith),
    .load_val (load_val),
    .dec      (state != IDLE),
    .term     (term)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (flush_act) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:     if (arith) state <= op[1] ? DIV_WAIT : MUL_WAIT;
        MUL_WAIT,
        DIV_WAIT: if (term) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: directed scenarios then random traffic against a cycle-count model.
module tb_md_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op;
  logic       op_ready, stall, md_busy;
  logic       md_start, md_hiwrite, md_lowrite;
  logic [2:0] md_ctr;
  logic       rd_valid, rd_sel;
  logic       flush;

  int total = 0;
  int bad   = 0;
  int mwait = 0;   // model: cycles the unit still blocks issue

  always #5 clk = ~clk;

  md_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .op_ready   (op_ready),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_start   (md_start),
    .md_hiwrite (md_hiwrite),
    .md_lowrite (md_lowrite),
    .md_ctr     (md_ctr),
    .rd_valid   (rd_valid),
    .rd_sel     (rd_sel),
    .flush      (flush)
  );

  function automatic logic flush_eff();
`ifdef MD_FLUSH_EN
    return flush;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic rdy, f, st;
    rdy = rst && (mwait == 0) && !md_busy && !flush_eff();
    f   = op_valid && rdy;
    st  = f && (op < 3'd4);
    chk("op_ready",   {7'd0, op_ready},   {7'd0, rdy});
    chk("stall",      {7'd0, stall},      {7'd0, rst && op_valid && !rdy});
    chk("md_start",   {7'd0, md_start},   {7'd0, st});
    chk("md_ctr",     {5'd0, md_ctr},     st ? {6'd0, op[1:0]} : 8'd0);
    chk("md_hiwrite", {7'd0, md_hiwrite}, {7'd0, f && op == 3'd4});
    chk("md_lowrite", {7'd0, md_lowrite}, {7'd0, f && op == 3'd5});
    chk("rd_valid",   {7'd0, rd_valid},   {7'd0, f && op >= 3'd6});
    chk("rd_sel",     {7'd0, rd_sel},     {7'd0, f && op == 3'd6});
  endtask

  task automatic look();
    #2;
    check_all();
  endtask

  // Model update for the coming edge, then step to just after it.
  task automatic tick();
    logic rdy;
    rdy = rst && (mwait == 0) && !md_busy && !flush_eff();
    if (!rst || flush_eff())               mwait = 0;
    else if (op_valid && rdy && op < 3'd4) mwait = (op < 3'd2) ? 5 : 10;
    else if (mwait > 0)                    mwait--;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b0; op_valid = 1'b1; op = 3'd0; md_busy = 1'b0; flush = 1'b0;

    // Reset: everything gated low even with an op presented.
    look();
    chk("rst_ready", {7'd0, op_ready}, 8'd0);
    tick();
    tick();
    rst = 1'b1;
    op_valid = 1'b0;
    tick();

    // MULT then a held MFLO: blocked for exactly 5 cycles.
    op_valid = 1'b1; op = 3'd0;
    look();
    chk("mult_start", {7'd0, md_start}, 8'd1);
    tick();
    op = 3'd7;
    n = 0;
    for (int unsigned i = 0; i < 20; i++) begin
      look();
      if (rd_valid) break;
      n++;
      tick();
    end
    chk("mult_block_cycles", 8'(n), 8'd5);
    chk("mflo_sel", {7'd0, rd_sel}, 8'd0);
    tick();

    // DIVU then a held MFHI: blocked for exactly 10 cycles.
    op = 3'd3;
    look();
    chk("divu_ctr", {5'd0, md_ctr}, 8'd3);
    tick();
    op = 3'd6;
    n = 0;
    for (int unsigned i = 0; i < 30; i++) begin
      look();
      if (rd_valid) break;
      n++;
      tick();
    end
    chk("div_block_cycles", 8'(n), 8'd10);
    chk("mfhi_sel", {7'd0, rd_sel}, 8'd1);
    tick();

    // MTHI, MTLO back to back: no wait.
    op = 3'd4;
    look();
    chk("mthi_pulse", {7'd0, md_hiwrite}, 8'd1);
    tick();
    op = 3'd5;
    look();
    chk("mtlo_pulse", {7'd0, md_lowrite}, 8'd1);
    chk("mtlo_ready", {7'd0, op_ready}, 8'd1);
    tick();

    // Unit busy in IDLE holds off MULTU.
    op = 3'd1; md_busy = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      look();
      tick();
    end
    md_busy = 1'b0;
    look();
    chk("multu_after_busy", {7'd0, md_start}, 8'd1);
    tick();
    op_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();

    // Reset in DIV_WAIT with cnt=6; release mid-cycle and MULT fires at once.
    op_valid = 1'b1; op = 3'd2;
    look();
    tick();
    op_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      look();
      tick();
    end
    op_valid = 1'b1; op = 3'd0;
    #1 rst = 1'b0;
    mwait = 0;
    #1 check_all();
    chk("rst_mid_ready", {7'd0, op_ready}, 8'd0);
    #1 rst = 1'b1;
    #1 check_all();
    chk("post_rst_start", {7'd0, md_start}, 8'd1);
    tick();
    op_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();

`ifdef MD_FLUSH_EN
    op_valid = 1'b1; op = 3'd0; flush = 1'b1;
    look();
    chk("flush_blocks_start", {7'd0, md_start}, 8'd0);
    chk("flush_stall", {7'd0, stall}, 8'd1);
    tick();
    flush = 1'b0;
    look();
    tick();
    op_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    look();
    tick();
    flush = 1'b0;
    look();
    chk("flush_to_idle", {7'd0, op_ready}, 8'd1);
    tick();
`else
    op_valid = 1'b1; op = 3'd0; flush = 1'b1;
    look();
    chk("flush_ignored", {7'd0, md_start}, 8'd1);
    tick();
    flush = 1'b0; op_valid = 1'b0;
    for (int unsigned i = 0; i < 5; i++) tick();
`endif

    // Random traffic against the model.
    for (int unsigned i = 0; i < 400; i++) begin
      op_valid = 1'($urandom_range(0, 1));
      op       = 3'($urandom_range(0, 7));
      md_busy  = ($urandom_range(0, 7) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      look();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL provide clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide op_valid  input  1  E-stage presents a multiply/divide-class instruction.
REQ-004 SHALL provide op  input  3  opcode: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101, MFHI=110, MFLO=111.
REQ-005 SHALL provide op_ready  output  1  controller accepts op this cycle.
REQ-006 SHALL provide stall  output  1  pipeline freeze request.
REQ-007 SHALL provide md_busy  input  1  busy flag from the mult/div unit.
REQ-008 SHALL provide md_start, md_hiwrite, md_lowrite  output  1 each  unit command strobes.
REQ-009 SHALL provide md_ctr  output  3  unit operation select.
REQ-010 SHALL provide rd_valid  output  1  HI/LO read accepted this cycle; rd_sel  output  1  1=HI, 0=LO.
REQ-011 SHALL provide flush  input  1  cancel request (used only under MD_FLUSH_EN).

Function
REQ-012 SHALL implement states IDLE, MUL_WAIT, DIV_WAIT plus a 4-bit down-counter cnt.
REQ-013 SHALL drive op_ready = (state==IDLE) && !md_busy; fire = op_valid && op_ready.
REQ-014 SHALL drive stall = op_valid && !op_ready, combinationally.
REQ-015 SHALL on fire with op in {000..011} assert md_start for exactly that cycle, with md_ctr = {1'b0, op[1:0]}.
REQ-016 SHALL on a fired MULT/MULTU load cnt=MUL_LAT (5) and enter MUL_WAIT; on a fired DIV/DIVU load cnt=DIV_LAT (10) and enter DIV_WAIT.
REQ-017 SHALL decrement cnt every cycle in MUL_WAIT/DIV_WAIT and return to IDLE on the edge where cnt==1.
REQ-017 consequence: op_ready is low for exactly 5 (mult) or 10 (div) cycles after the issue cycle.
REQ-018 SHALL on fire with MTHI/MTLO pulse md_hiwrite/md_lowrite for one cycle, with no state change and no wait.
REQ-019 SHALL on fire with MFHI/MFLO pulse rd_valid with rd_sel=~op[0], with no state change.
REQ-020 SHALL keep md_ctr=000 and all strobes low whenever fire is low; no output is ever registered.
REQ-021 SHALL give md_busy priority: if md_busy is high in IDLE, op_ready stays low until md_busy falls.
REQ-022 SHALL treat back-to-back ops identically: an op presented on the cycle state returns to IDLE fires that cycle.

Reset
REQ-023 SHALL on rst low, immediately and regardless of clk, force state=IDLE and cnt=0.
REQ-024 SHALL during reset hold op_ready=!md_busy gated low by reset, with all strobes, rd_valid and stall low.
REQ-025 SHALL on reset mid-operation abandon the count; the first cycle after release behaves as IDLE.

Configuration
REQ-026 SHALL with MD_FLUSH_EN defined force op_ready and all strobes low while flush=1, and on that edge force state=IDLE and cnt=0; md_busy gating still applies afterwards.
REQ-027 SHALL without MD_FLUSH_EN keep the flush port present but ignored entirely.

Structure
REQ-028 SHALL place opcode constants, MUL_LAT, DIV_LAT and state encodings in shared package md_pkg.
REQ-029 SHALL implement the latency down-counter (load, decrement, terminal flag) as sub-module md_lat_cnt.

Verification
REQ-030 MULT issued from IDLE -> md_start=1 and md_ctr=000 in cycle 0; op_ready low cycles 1-5; a MFLO held valid fires in cycle 6 with rd_valid=1 and rd_sel=0.
REQ-031 DIVU issued -> md_ctr=011; stall=1 for a following MFHI over 10 cycles; MFHI fires on cycle 11.
REQ-032 MTHI then MTLO on consecutive cycles -> md_hiwrite pulse, then md_lowrite pulse, with op_ready high throughout.
REQ-033 md_busy forced high in IDLE with MULTU valid -> stall=1 and md_start=0 until md_busy falls.
REQ-034 rst low at DIV_WAIT cnt=6 -> state=IDLE asynchronously; after release, MULT fires on the first cycle.
REQ-035 MD_FLUSH_EN build, flush=1 with MULT valid in IDLE -> md_start=0 and stall=1; flush at MUL_WAIT cnt=3 -> IDLE next edge.
